// File: rtl/main_pkg.sv
// Shared sizes, FSM state encoding and reset-image helper for the bubble-sort slave.
// Pure declarations; no timing or flow control.
package main_pkg;
   localparam int N_ELEMS   = 100;
   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 9;
   localparam int CH_DATA_W = 64;
   localparam int SIZE_W    = 7;
   localparam int N_CH      = 2;
   localparam int IDX_W     = 7;

   typedef enum logic [1:0] {
      IDLE,
      CMP,
      PASS_END,
      DONE
   } state_t;

   // Reset image is the worst case for bubble sort: strictly descending 100..1.
   function automatic logic [DATA_W-1:0] init_val(input int i);
      return DATA_W'(N_ELEMS - i);
   endfunction
endpackage

// File: rtl/main_if.sv
// Decoded per-channel array access between the slave port and the array owner.
// Combinational request/response; no backpressure.
interface main_if;
   import main_pkg::*;

   logic [N_CH-1:0]             w_wr_vld;
   logic [N_CH-1:0][IDX_W-1:0]  w_idx;
   logic [N_CH-1:0][DATA_W-1:0] w_wr_dat;
   logic [N_CH-1:0][DATA_W-1:0] w_rd_dat;

   modport master (output w_wr_vld, w_idx, w_wr_dat, input w_rd_dat);
   modport slave  (input w_wr_vld, w_idx, w_wr_dat, output w_rd_dat);
endinterface

// File: rtl/main_slave_port.sv
// Two-channel slave decode: address/size check, registered read data and ack.
// Ack and read data one cycle after oe/we; never stalls the requester.
module main_slave_port
   import main_pkg::*;
#(
   parameter int WORD_BASE = 32
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [N_CH-1:0]           i_oe,
   input  logic [N_CH-1:0]           i_we,
   input  logic [N_CH*ADDR_W-1:0]    i_addr,
   input  logic [N_CH*CH_DATA_W-1:0] i_wdata,
   input  logic [N_CH*SIZE_W-1:0]    i_size,
   main_if.master                    bus,
   output logic [N_CH*CH_DATA_W-1:0] o_rdata,
   output logic [N_CH-1:0]           o_rdy
);
   logic [N_CH-1:0]             w_hit;
   logic [N_CH-1:0][ADDR_W-1:0] w_off;
   logic [N_CH*CH_DATA_W-1:0]   r_rdata;
   logic [N_CH-1:0]             r_rdy;
   logic                        w_unused;

   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         w_off[k]        = i_addr[k*ADDR_W +: ADDR_W] - ADDR_W'(WORD_BASE);
         w_hit[k]        = (i_addr[k*ADDR_W +: ADDR_W] >= ADDR_W'(WORD_BASE)) &&
                           (w_off[k] < ADDR_W'(N_ELEMS)) &&
                           (i_size[k*SIZE_W +: SIZE_W] == SIZE_W'(DATA_W));
         bus.w_idx[k]    = w_hit[k] ? w_off[k][IDX_W-1:0] : '0;
         bus.w_wr_vld[k] = i_we[k] & w_hit[k];
         bus.w_wr_dat[k] = i_wdata[k*CH_DATA_W +: DATA_W];
      end
   end

   // Only the low word of each channel's write lane is stored.
   assign w_unused = ^{i_wdata[2*CH_DATA_W-1:CH_DATA_W+DATA_W], i_wdata[CH_DATA_W-1:DATA_W]};

   // Read data is captured before any same-edge write lands, so oe+we returns the old word.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rdy   <= '0;
         r_rdata <= '0;
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            r_rdy[k] <= i_oe[k] | i_we[k];
            r_rdata[k*CH_DATA_W +: CH_DATA_W] <= (i_oe[k] && w_hit[k]) ?
               {{(CH_DATA_W-DATA_W){1'b0}}, bus.w_rd_dat[k]} : '0;
         end
      end
   end

   assign o_rdata = r_rdata;
   assign o_rdy   = r_rdy;
endmodule

// File: rtl/main.sv
// In-place signed bubble sort of a 100-word array, one compare per cycle; slave port stays live.
// Full sort 5049 busy cycles then a one-cycle done_port; MAIN_EARLY_EXIT_EN ends after a swap-free pass.
module main
   import main_pkg::*;
#(
   parameter int MEM_var_26078_26084 = 128
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start_port,
   input  logic [1:0]   S_oe_ram,
   input  logic [1:0]   S_we_ram,
   input  logic [17:0]  S_addr_ram,
   input  logic [127:0] S_Wdata_ram,
   input  logic [13:0]  S_data_ram_size,
   output logic         done_port,
   output logic [127:0] Sout_Rdata_ram,
   output logic [1:0]   Sout_DataRdy
);
   localparam int WORD_BASE = MEM_var_26078_26084 / 4;

   state_t              r_state, w_state_nxt;
   logic [IDX_W-1:0]    r_j, r_p;
   logic                r_swapped;
   logic [DATA_W-1:0]   r_arr [N_ELEMS];
   logic                w_gt, w_last_cmp, w_last_pass, w_finish;

   main_if u_bus ();

   main_slave_port #(.WORD_BASE(WORD_BASE)) u_slave (
      .clock   (clock),
      .reset   (reset),
      .i_oe    (S_oe_ram),
      .i_we    (S_we_ram),
      .i_addr  (S_addr_ram),
      .i_wdata (S_Wdata_ram),
      .i_size  (S_data_ram_size),
      .bus     (u_bus.master),
      .o_rdata (Sout_Rdata_ram),
      .o_rdy   (Sout_DataRdy)
   );

   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         u_bus.w_rd_dat[k] = r_arr[u_bus.w_idx[k]];
      end
   end

   assign w_gt        = $signed(r_arr[r_j]) > $signed(r_arr[r_j + 7'd1]);
   assign w_last_cmp  = (r_j == IDX_W'(N_ELEMS - 2) - r_p);
   assign w_last_pass = (r_p == IDX_W'(N_ELEMS - 2));

`ifdef MAIN_EARLY_EXIT_EN
   assign w_finish = w_last_pass | ~r_swapped;
`else
   assign w_finish = w_last_pass;
`endif

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      done_port   = 1'b0;
      case (r_state)
         IDLE:     if (start_port) w_state_nxt = CMP;
         CMP:      if (w_last_cmp) w_state_nxt = PASS_END;
         PASS_END: w_state_nxt = w_finish ? DONE : CMP;
         DONE: begin
            done_port   = 1'b1;
            w_state_nxt = IDLE;
         end
         default:  w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_j       <= '0;
         r_p       <= '0;
         r_swapped <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (start_port) begin
               r_j       <= '0;
               r_p       <= '0;
               r_swapped <= 1'b0;
            end
            CMP: begin
               if (w_gt)        r_swapped <= 1'b1;
               if (!w_last_cmp) r_j <= r_j + 7'd1;
            end
            PASS_END: begin
               r_j       <= '0;
               r_p       <= r_p + 7'd1;
               r_swapped <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Host writes land only while idle; channel 1 is applied last so it wins a same-word collision.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < N_ELEMS; i++) r_arr[i] <= init_val(i);
      end else if (r_state == CMP) begin
         if (w_gt) begin
            r_arr[r_j]        <= r_arr[r_j + 7'd1];
            r_arr[r_j + 7'd1] <= r_arr[r_j];
         end
      end else if (r_state == IDLE) begin
         for (int k = 0; k < N_CH; k++) begin
            if (u_bus.w_wr_vld[k]) r_arr[u_bus.w_idx[k]] <= u_bus.w_wr_dat[k];
         end
      end
   end
endmodule

// File: tb/tb_main.sv
// Scoreboarded bench for main: slave reads/writes, sort latency, early exit, abort by reset.
module tb_main;
   import main_pkg::*;

   logic         clock = 1'b0;
   logic         reset;
   logic         start_port;
   logic [1:0]   S_oe_ram, S_we_ram;
   logic [17:0]  S_addr_ram;
   logic [127:0] S_Wdata_ram;
   logic [13:0]  S_data_ram_size;
   logic         done_port;
   logic [127:0] Sout_Rdata_ram;
   logic [1:0]   Sout_DataRdy;

   always #5 clock = ~clock;

   main dut (
      .clock           (clock),
      .reset           (reset),
      .start_port      (start_port),
      .S_oe_ram        (S_oe_ram),
      .S_we_ram        (S_we_ram),
      .S_addr_ram      (S_addr_ram),
      .S_Wdata_ram     (S_Wdata_ram),
      .S_data_ram_size (S_data_ram_size),
      .done_port       (done_port),
      .Sout_Rdata_ram  (Sout_Rdata_ram),
      .Sout_DataRdy    (Sout_DataRdy)
   );

   typedef struct {
      bit          chk;
      logic [31:0] d;
   } exp_t;

   exp_t        q0[$], q1[$];
   int          n_tot = 0, n_bad = 0, n_done = 0;
   logic [31:0] model [100];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   // Output monitor: counts done pulses and retires scoreboard entries on each ack.
   always @(negedge clock) begin
      exp_t e;
      if (done_port === 1'b1) n_done++;
      if (Sout_DataRdy[0] === 1'b1) begin
         if (q0.size() == 0) chk("spurious_ack0", 1, 0);
         else begin
            e = q0.pop_front();
            if (e.chk) chk("rdata0", Sout_Rdata_ram[63:0], {32'h0, e.d});
         end
      end
      if (Sout_DataRdy[1] === 1'b1) begin
         if (q1.size() == 0) chk("spurious_ack1", 1, 0);
         else begin
            e = q1.pop_front();
            if (e.chk) chk("rdata1", Sout_Rdata_ram[127:64], {32'h0, e.d});
         end
      end
   end

   task automatic bus_idle();
      S_oe_ram        = '0;
      S_we_ram        = '0;
      S_addr_ram      = '0;
      S_Wdata_ram     = '0;
      S_data_ram_size = '0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 100; i++) model[i] = 32'(100 - i);
   endtask

   task automatic sort_model();
      for (int i = 1; i < 100; i++) begin
         logic [31:0] key;
         int          j;
         key = model[i];
         j   = i - 1;
         while (j >= 0 && $signed(model[j]) > $signed(key)) begin
            model[j+1] = model[j];
            j--;
         end
         model[j+1] = key;
      end
   endtask

   // One bus cycle on both channels; expectations use the pre-write model.
   task automatic bus_cycle(input logic [1:0] oe, input logic [1:0] we, input int a0, input int a1,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [6:0] sz0, input logic [6:0] sz1, input bit idle);
      int          a[2];
      logic [31:0] d[2];
      logic [6:0]  sz[2];
      bit          hit[2];
      exp_t        e;
      a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1; sz[0] = sz0; sz[1] = sz1;
      for (int k = 0; k < 2; k++) begin
         hit[k] = (a[k] >= 32) && (a[k] <= 131) && (sz[k] == 7'd32);
         if (oe[k] || we[k]) begin
            e.chk = oe[k];
            e.d   = (oe[k] && hit[k]) ? model[a[k]-32] : 32'h0;
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
         end
      end
      for (int k = 0; k < 2; k++)
         if (we[k] && hit[k] && idle) model[a[k]-32] = d[k];
      S_oe_ram        = oe;
      S_we_ram        = we;
      S_addr_ram      = {9'(a1), 9'(a0)};
      S_Wdata_ram     = {32'hA5A5A5A5, d1, 32'h5A5A5A5A, d0};
      S_data_ram_size = {sz1, sz0};
      @(posedge clock); #1;
      bus_idle();
   endtask

   task automatic readback();
      for (int i = 0; i < 50; i++)
         bus_cycle(2'b11, 2'b00, 32 + i, 82 + i, 32'h0, 32'h0, 7'd32, 7'd32, 1'b1);
   endtask

   // Start a sort; optionally poke start and a write mid-sort, both of which must be ignored.
   task automatic run_sort(input int exp_cyc, input bit poke);
      int   cyc;
      int   d0;
      exp_t e;
      d0 = n_done;
      start_port = 1'b1;
      @(posedge clock); #1;
      start_port = 1'b0;
      cyc = 1;
      while (done_port !== 1'b1 && cyc < 7000) begin
         if (poke && cyc == 500) begin
            start_port      = 1'b1;
            S_we_ram        = 2'b01;
            S_addr_ram      = 18'(50);
            S_Wdata_ram     = 128'hDEAD;
            S_data_ram_size = 14'(32);
            e.chk = 1'b0;
            e.d   = 32'h0;
            q0.push_back(e);
         end
         @(posedge clock); #1;
         start_port = 1'b0;
         bus_idle();
         cyc++;
      end
      chk("latency", 64'(cyc), 64'(exp_cyc));
      @(posedge clock); #1;
      chk("done_1cyc", {63'h0, done_port}, 64'h0);
      repeat (20) @(posedge clock);
      #1;
      chk("done_cnt", 64'(n_done - d0), 64'd1);
      sort_model();
   endtask

   initial begin
      int d0;
      reset      = 1'b1;
      start_port = 1'b0;
      bus_idle();
      repeat (3) @(posedge clock);
      #1;
      chk("rst_done", {63'h0, done_port}, 64'h0);
      chk("rst_rdy", {62'h0, Sout_DataRdy}, 64'h0);
      chk("rst_rdata_lo", Sout_Rdata_ram[63:0], 64'h0);
      chk("rst_rdata_hi", Sout_Rdata_ram[127:64], 64'h0);
      reset = 1'b0;
      model_reset();
      readback();

      run_sort(5050, 1'b1);
      readback();

      bus_cycle(2'b01, 2'b00, 200, 0, 32'h0, 32'h0, 7'd32, 7'd32, 1'b1);
      bus_cycle(2'b11, 2'b00, 31, 132, 32'h0, 32'h0, 7'd32, 7'd32, 1'b1);
      bus_cycle(2'b01, 2'b00, 40, 0, 32'h0, 32'h0, 7'd16, 7'd32, 1'b1);
      bus_cycle(2'b00, 2'b01, 45, 0, 32'h99, 32'h0, 7'd8, 7'd32, 1'b1);

`ifdef MAIN_EARLY_EXIT_EN
      run_sort(101, 1'b0);
`else
      run_sort(5050, 1'b0);
`endif
      readback();

      bus_cycle(2'b00, 2'b11, 32, 33, 32'd7, 32'd5, 7'd32, 7'd32, 1'b1);
`ifdef MAIN_EARLY_EXIT_EN
      run_sort(298, 1'b0);
`else
      run_sort(5050, 1'b0);
`endif
      readback();

      bus_cycle(2'b00, 2'b01, 131, 0, 32'hFFFFFFFF, 32'h0, 7'd32, 7'd32, 1'b1);
      run_sort(5050, 1'b0);
      readback();

      bus_cycle(2'b00, 2'b11, 40, 40, 32'd11, 32'd22, 7'd32, 7'd32, 1'b1);
      bus_cycle(2'b01, 2'b00, 40, 0, 32'h0, 32'h0, 7'd32, 7'd32, 1'b1);
      bus_cycle(2'b01, 2'b01, 41, 0, 32'd55, 32'h0, 7'd32, 7'd32, 1'b1);
      readback();

      d0 = n_done;
      start_port = 1'b1;
      @(posedge clock); #1;
      start_port = 1'b0;
      repeat (999) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (5200) @(posedge clock);
      #1;
      chk("abort_no_done", 64'(n_done - d0), 64'd0);
      model_reset();
      readback();

      repeat (3) @(posedge clock);
      #1;
      chk("q_empty", 64'(q0.size() + q1.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
